alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Initiator side of the ALU operand/result interface.
- Accepts one operation request at a time over a valid/ready handshake and drives the ALU operand/control inputs (reg1, reg2, control, inc_pc), holding them stable.
- Waits a fixed settle time, then captures the ALU's 64-bit z result into HI/LO result registers and returns it over a valid/ready response handshake.
- Screens illegal opcodes before issue.

Parameters:
- DATA_W, 32, operand width; result is 2*DATA_W.
- SETTLE_CYCLES, 2, Clk cycles from issue to result capture; legal range 1..15.

Ports:
- Clk  in  1  system clock; all state updates on posedge.
- Rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept; high only in IDLE.
- req_op  in  4  ALU control code: 0 div, 1 mul, 2 add, 3 sub, 4 shl, 5 shr, 6 ror, 7 rol, 8 or, 9 neg, 10 and, 11 not.
- req_pc_inc  in  1  PC-increment request; req_op ignored.
- req_a  in  DATA_W  operand to ALU reg1.
- req_b  in  DATA_W  operand to ALU reg2.
- alu_reg1  out  DATA_W  to ALU reg1.
- alu_reg2  out  DATA_W  to ALU reg2.
- alu_control  out  4  to ALU control.
- alu_inc_pc  out  1  to ALU inc_pc.
- alu_z  in  2*DATA_W  ALU z_Output.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_lo  out  DATA_W  low result word: quotient, product[31:0], or single-word result.
- rsp_hi  out  DATA_W  high result word: remainder or product[63:32]; 0 otherwise.
- rsp_err  out  1  request rejected; rsp_lo and rsp_hi are meaningless except as stated below.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (Rst_n=0 at posedge):
  - State goes to IDLE.
  - All outputs go to 0, except req_ready=1.
  - Any in-flight transaction is dropped; no response is produced.
  - Reset dominates all other inputs in the same cycle.
- States: IDLE, WAIT, RESP.
- IDLE:
  - Accept occurs when req_valid && req_ready at posedge.
  - On accept, latch req_a→alu_reg1, req_b→alu_reg2, req_op→alu_control, req_pc_inc→alu_inc_pc.
  - Load the wait counter with SETTLE_CYCLES-1 and go to WAIT.
  - Exception: if req_pc_inc=0 and req_op>=12, the ALU is not issued: alu_* outputs are unchanged, rsp_err is set, rsp_lo=rsp_hi=0, and the state goes directly to RESP.
- WAIT:
  - alu_* outputs are held constant.
  - The counter decrements each cycle.
  - When the counter is 0, capture into the result registers and go to RESP:
    - alu_inc_pc=1: rsp_lo=alu_z[31:0], rsp_hi=0.
    - op 0 or 1: rsp_lo=alu_z[31:0], rsp_hi=alu_z[63:32].
    - ops 2..11: rsp_lo=alu_z[31:0], rsp_hi=0.
    - rsp_err=0.
- RESP:
  - rsp_valid=1, and rsp_* are stable until rsp_valid && rsp_ready at posedge, then go to IDLE.
  - rsp_valid falls the cycle after that handshake.
  - alu_* outputs hold their last values until the next accept.
- Latency:
  - Accept at edge N → rsp_valid first high in the cycle after edge N+SETTLE_CYCLES.
  - Rejected request → rsp_valid high after edge N+1.
- Throughput: one request in flight; req_ready=0 in WAIT and RESP.
  - With rsp_ready held high, back-to-back requests cost SETTLE_CYCLES+2 cycles each.
- req_valid asserted while busy is ignored and not queued.
- req_* are sampled only at the accept edge; later changes have no effect.

Optional Feature:
- Macro: ALU_SEQ_DIV_ZERO_TRAP_EN.
- When defined, a request with req_pc_inc=0, req_op=0 and req_b=0 is not issued to the ALU:
  - Go directly to RESP with rsp_err=1, rsp_lo=all ones, rsp_hi=req_a.
  - Same one-cycle latency as an illegal opcode.
- When not defined, divide-by-zero issues normally: rsp_err=0 and the result is whatever alu_z returns.

Test Plan:
- Add: SETTLE_CYCLES=2, accept op=2, a=5, b=7; stub ALU returns z=12 → alu_reg1=5, alu_reg2=7, alu_control=2 held; rsp_valid after edge N+2; rsp_lo=12, rsp_hi=0, rsp_err=0.
- Multiply: op=1, a=0x10000, b=0x10000; stub z=0x00000001_00000000 → rsp_hi=1, rsp_lo=0; rsp held for 3 cycles with rsp_ready=0, then released; req_ready returns one cycle later.
- Illegal opcode: op=13 → no change on alu_*; rsp_valid after edge N+1; rsp_err=1, rsp_lo=0, rsp_hi=0.
- Divide by zero: op=0, a=9, b=0 → with macro: rsp_err=1, rsp_lo=0xFFFFFFFF, rsp_hi=9, ALU not issued; without macro: issued, rsp_err=0.
- Reset mid-WAIT: Rst_n=0 for one edge during WAIT → next cycle IDLE, req_ready=1, rsp_valid stays 0, and no stale response appears afterwards.
- PC increment and busy requests: req_pc_inc=1, op=7, b=0x40; stub z=0x41 → alu_inc_pc=1, rsp_lo=0x41, rsp_hi=0; a second req_valid pulse during WAIT is ignored.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: initiator for the ALU operand/result interface; issues one op, waits, returns z.
// Latency: accept at edge N -> rsp_valid after edge N+SETTLE_CYCLES; rejected request -> after edge N+1.
// Backpressure: req_ready only while idle (busy requests are dropped, not queued); response held until rsp_ready.
//
// Ports:
//   Clk, Rst_n        clock, synchronous active-low reset
//   req_*             request handshake: op code, pc-increment flag, operands a/b
//   alu_*             registered operand/control drive to the ALU, held stable between accepts
//   alu_z             ALU result, captured SETTLE_CYCLES after issue
//   rsp_*             response handshake: lo/hi result words, error flag
//   busy              high whenever a request is in flight
//
// Build option: define ALU_SEQ_DIV_ZERO_TRAP_EN to reject divide-by-zero before issue
// (error response with lo = all ones, hi = dividend). Default build issues it to the ALU.

module alu_op_sequencer #(
  parameter int DATA_W        = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [3:0]          req_op,
  input  logic                req_pc_inc,
  input  logic [DATA_W-1:0]   req_a,
  input  logic [DATA_W-1:0]   req_b,
  output logic [DATA_W-1:0]   alu_reg1,
  output logic [DATA_W-1:0]   alu_reg2,
  output logic [3:0]          alu_control,
  output logic                alu_inc_pc,
  input  logic [2*DATA_W-1:0] alu_z,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_lo,
  output logic [DATA_W-1:0]   rsp_hi,
  output logic                rsp_err,
  output logic                busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  // Set when the accepted request was screened out; the WAIT pass then
  // leaves the pre-loaded error response untouched instead of sampling alu_z.
  logic       rejected;

  logic illegal_op;
  logic div_trap;
  logic reject;

  always_comb begin
    illegal_op = !req_pc_inc && (req_op >= 4'd12);
`ifdef ALU_SEQ_DIV_ZERO_TRAP_EN
    div_trap   = !req_pc_inc && (req_op == 4'd0) && (req_b == '0);
`else
    div_trap   = 1'b0;
`endif
    reject     = illegal_op || div_trap;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      rejected    <= 1'b0;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      alu_reg1    <= '0;
      alu_reg2    <= '0;
      alu_control <= '0;
      alu_inc_pc  <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_lo      <= '0;
      rsp_hi      <= '0;
      rsp_err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_WAIT;
            if (reject) begin
              // ALU is not touched; the error response is staged now (rsp_valid
              // is still low) and released after a single WAIT cycle.
              rejected <= 1'b1;
              cnt      <= '0;
              rsp_err  <= 1'b1;
              rsp_lo   <= div_trap ? '1 : '0;
              rsp_hi   <= div_trap ? req_a : '0;
            end else begin
              rejected    <= 1'b0;
              cnt         <= CNT_LOAD;
              alu_reg1    <= req_a;
              alu_reg2    <= req_b;
              alu_control <= req_op;
              alu_inc_pc  <= req_pc_inc;
            end
          end
        end

        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            if (!rejected) begin
              rsp_err <= 1'b0;
              rsp_lo  <= alu_z[DATA_W-1:0];
              // Only div (0) and mul (1) produce a meaningful upper word.
              rsp_hi  <= (!alu_inc_pc && (alu_control < 4'd2)) ? alu_z[2*DATA_W-1:DATA_W] : '0;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end

        default: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: randomized and directed stimulus for alu_op_sequencer against a behavioural model.
// Latency: n/a (bench).
// Backpressure: exercises rsp_ready hold-off and req_valid while busy.

module tb_alu_op_sequencer;

  localparam int DW = 32;
  localparam int S  = 2;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_op;
  logic          req_pc_inc;
  logic [DW-1:0] req_a;
  logic [DW-1:0] req_b;
  logic [DW-1:0] alu_reg1;
  logic [DW-1:0] alu_reg2;
  logic [3:0]    alu_control;
  logic          alu_inc_pc;
  logic [2*DW-1:0] alu_z;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_lo;
  logic [DW-1:0] rsp_hi;
  logic          rsp_err;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // Model of what the ALU inputs should currently show.
  logic [DW-1:0] m_reg1 = '0;
  logic [DW-1:0] m_reg2 = '0;
  logic [3:0]    m_ctl  = '0;
  logic          m_inc  = 1'b0;

  always #5 Clk = ~Clk;

  alu_op_sequencer #(.DATA_W(DW), .SETTLE_CYCLES(S)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_pc_inc(req_pc_inc),
    .req_a(req_a), .req_b(req_b),
    .alu_reg1(alu_reg1), .alu_reg2(alu_reg2), .alu_control(alu_control), .alu_inc_pc(alu_inc_pc),
    .alu_z(alu_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_lo(rsp_lo), .rsp_hi(rsp_hi),
    .rsp_err(rsp_err), .busy(busy)
  );

  typedef struct {
    int            lat;
    logic [DW-1:0] lo;
    logic [DW-1:0] hi;
    logic          err;
    logic          issued;
  } exp_t;

  typedef struct {
    int            lat;
    logic [DW-1:0] lo;
    logic [DW-1:0] hi;
    logic          err;
    int            alu_bad;
    int            unstable;
    int            post_bad;
    int            busy_bad;
    time           acc_t;
  } obs_t;

  // Expected response from the request rules alone.
  function automatic exp_t model(input logic [3:0] op, input logic pc,
                                 input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic [2*DW-1:0] z);
    exp_t e;
    e.issued = 1'b1;
    e.err    = 1'b0;
    e.lat    = S;
    e.lo     = z[DW-1:0];
    e.hi     = '0;
    if (!pc && op >= 4'd12) begin
      e.issued = 1'b0; e.err = 1'b1; e.lat = 1; e.lo = '0; e.hi = '0;
    end
`ifdef ALU_SEQ_DIV_ZERO_TRAP_EN
    else if (!pc && op == 4'd0 && b == '0) begin
      e.issued = 1'b0; e.err = 1'b1; e.lat = 1; e.lo = '1; e.hi = a;
    end
`endif
    else if (!pc && op <= 4'd1) begin
      e.hi = z[2*DW-1:DW];
    end
    return e;
  endfunction

  // Drives one transaction and gathers observations. The stub ALU shows z only
  // in the cycle before the expected capture edge, garbage otherwise.
  task automatic run_txn(input logic [3:0] op, input logic pc, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [2*DW-1:0] z,
                         input int hold, input logic poke, output obs_t o);
    exp_t e;
    e = model(op, pc, a, b, z);
    if (e.issued) begin
      m_reg1 = a; m_reg2 = b; m_ctl = op; m_inc = pc;
    end
    o.lat = -1; o.lo = '0; o.hi = '0; o.err = 1'b0;
    o.alu_bad = 0; o.unstable = 0; o.post_bad = 0; o.busy_bad = 0;
    if (!req_ready || busy) o.busy_bad++;
    req_valid = 1'b1; req_op = op; req_pc_inc = pc; req_a = a; req_b = b;
    alu_z = {$urandom, $urandom};
    @(posedge Clk);
    o.acc_t = $time;
    #1;
    // Later request changes (and a busy req_valid pulse) must have no effect.
    req_valid = poke; req_op = 4'($urandom_range(15)); req_pc_inc = 1'($urandom_range(1));
    req_a = $urandom; req_b = $urandom;
    for (int k = 0; k <= 40; k++) begin
      alu_z = (k == S - 1) ? z : {$urandom, $urandom};
      if (rsp_valid) begin
        o.lat = k;
        break;
      end
      if (alu_reg1 !== m_reg1 || alu_reg2 !== m_reg2 || alu_control !== m_ctl || alu_inc_pc !== m_inc)
        o.alu_bad++;
      if (!busy || req_ready) o.busy_bad++;
      @(posedge Clk); #1;
    end
    req_valid = 1'b0;
    if (o.lat < 0) return;
    o.lo = rsp_lo; o.hi = rsp_hi; o.err = rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(posedge Clk); #1;
      alu_z = {$urandom, $urandom};
      if (!rsp_valid || rsp_lo !== o.lo || rsp_hi !== o.hi || rsp_err !== o.err) o.unstable++;
      if (!busy || req_ready) o.busy_bad++;
    end
    rsp_ready = 1'b1;
    @(posedge Clk); #1;
    rsp_ready = 1'b0;
    if (rsp_valid || !req_ready || busy) o.post_bad++;
    if (alu_reg1 !== m_reg1 || alu_reg2 !== m_reg2 || alu_control !== m_ctl || alu_inc_pc !== m_inc)
      o.alu_bad++;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_pc_inc = 1'b0; req_a = '0; req_b = '0;
    rsp_ready = 1'b0; alu_z = '0;
    repeat (2) @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset req_ready: got %b expected 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
    checks++; if ({alu_reg1, alu_reg2, alu_control, alu_inc_pc} !== '0) begin
      errors++; $display("FAIL reset alu_outputs: got %h %h %h %b expected zeros", alu_reg1, alu_reg2, alu_control, alu_inc_pc);
    end
    checks++; if ({rsp_lo, rsp_hi, rsp_err} !== '0) begin
      errors++; $display("FAIL reset rsp_fields: got %h %h %b expected zeros", rsp_lo, rsp_hi, rsp_err);
    end
    m_reg1 = '0; m_reg2 = '0; m_ctl = '0; m_inc = 1'b0;
  endtask

  task automatic test_add();
    obs_t o; exp_t e;
    e = model(4'd2, 1'b0, 32'd5, 32'd7, 64'd12);
    run_txn(4'd2, 1'b0, 32'd5, 32'd7, 64'd12, 0, 1'b0, o);
    checks++; if (o.lat !== e.lat) begin errors++; $display("FAIL add latency: got %0d expected %0d", o.lat, e.lat); end
    checks++; if (o.lo !== e.lo) begin errors++; $display("FAIL add lo: got %h expected %h", o.lo, e.lo); end
    checks++; if (o.hi !== e.hi) begin errors++; $display("FAIL add hi: got %h expected %h", o.hi, e.hi); end
    checks++; if (o.err !== e.err) begin errors++; $display("FAIL add err: got %b expected %b", o.err, e.err); end
    checks++; if (o.alu_bad !== 0) begin errors++; $display("FAIL add alu_hold: got %0d bad cycles expected 0", o.alu_bad); end
    checks++; if (o.post_bad + o.busy_bad !== 0) begin errors++; $display("FAIL add handshake: got %0d bad cycles expected 0", o.post_bad + o.busy_bad); end
  endtask

  task automatic test_mul_hold();
    obs_t o; exp_t e;
    e = model(4'd1, 1'b0, 32'h10000, 32'h10000, 64'h00000001_00000000);
    run_txn(4'd1, 1'b0, 32'h10000, 32'h10000, 64'h00000001_00000000, 3, 1'b0, o);
    checks++; if (o.lat !== e.lat) begin errors++; $display("FAIL mul latency: got %0d expected %0d", o.lat, e.lat); end
    checks++; if (o.lo !== e.lo || o.hi !== e.hi) begin errors++; $display("FAIL mul result: got %h_%h expected %h_%h", o.hi, o.lo, e.hi, e.lo); end
    checks++; if (o.err !== e.err) begin errors++; $display("FAIL mul err: got %b expected %b", o.err, e.err); end
    checks++; if (o.unstable !== 0) begin errors++; $display("FAIL mul rsp_stable: got %0d bad cycles expected 0", o.unstable); end
    checks++; if (o.alu_bad !== 0) begin errors++; $display("FAIL mul alu_hold: got %0d bad cycles expected 0", o.alu_bad); end
    checks++; if (o.post_bad + o.busy_bad !== 0) begin errors++; $display("FAIL mul handshake: got %0d bad cycles expected 0", o.post_bad + o.busy_bad); end
  endtask

  task automatic test_illegal_op();
    obs_t o; exp_t e;
    logic [2*DW-1:0] z;
    z = {$urandom, $urandom};
    e = model(4'd13, 1'b0, 32'h1234, 32'h5678, z);
    run_txn(4'd13, 1'b0, 32'h1234, 32'h5678, z, 1, 1'b0, o);
    checks++; if (o.lat !== e.lat) begin errors++; $display("FAIL illegal latency: got %0d expected %0d", o.lat, e.lat); end
    checks++; if (o.lo !== e.lo || o.hi !== e.hi) begin errors++; $display("FAIL illegal result: got %h_%h expected %h_%h", o.hi, o.lo, e.hi, e.lo); end
    checks++; if (o.err !== e.err) begin errors++; $display("FAIL illegal err: got %b expected %b", o.err, e.err); end
    checks++; if (o.alu_bad !== 0) begin errors++; $display("FAIL illegal alu_unchanged: got %0d bad cycles expected 0", o.alu_bad); end
    checks++; if (o.post_bad + o.busy_bad + o.unstable !== 0) begin errors++; $display("FAIL illegal handshake: got %0d bad cycles expected 0", o.post_bad + o.busy_bad + o.unstable); end
  endtask

  task automatic test_div_zero();
    obs_t o; exp_t e;
    logic [2*DW-1:0] z;
    z = {$urandom, $urandom};
    e = model(4'd0, 1'b0, 32'd9, 32'd0, z);
    run_txn(4'd0, 1'b0, 32'd9, 32'd0, z, 0, 1'b0, o);
    checks++; if (o.lat !== e.lat) begin errors++; $display("FAIL div0 latency: got %0d expected %0d", o.lat, e.lat); end
    checks++; if (o.lo !== e.lo || o.hi !== e.hi) begin errors++; $display("FAIL div0 result: got %h_%h expected %h_%h", o.hi, o.lo, e.hi, e.lo); end
    checks++; if (o.err !== e.err) begin errors++; $display("FAIL div0 err: got %b expected %b", o.err, e.err); end
    checks++; if (o.alu_bad !== 0) begin errors++; $display("FAIL div0 alu_outputs: got %0d bad cycles expected 0", o.alu_bad); end
  endtask

  task automatic test_reset_mid_wait();
    int stray;
    req_valid = 1'b1; req_op = 4'd2; req_pc_inc = 1'b0; req_a = $urandom; req_b = $urandom;
    @(posedge Clk); #1;
    req_valid = 1'b0;
    Rst_n = 1'b0;
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    m_reg1 = '0; m_reg2 = '0; m_ctl = '0; m_inc = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstwait req_ready: got %b expected 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstwait idle: got rsp_valid=%b busy=%b expected 0 0", rsp_valid, busy); end
    checks++; if (alu_reg1 !== '0 || alu_control !== '0) begin errors++; $display("FAIL rstwait alu_cleared: got %h %h expected 0 0", alu_reg1, alu_control); end
    stray = 0;
    rsp_ready = 1'b1;
    repeat (S + 6) begin
      @(posedge Clk); #1;
      if (rsp_valid || busy) stray++;
    end
    rsp_ready = 1'b0;
    checks++; if (stray !== 0) begin errors++; $display("FAIL rstwait stale_rsp: got %0d cycles expected 0", stray); end
  endtask

  task automatic test_pc_inc_busy();
    obs_t o; exp_t e;
    logic [DW-1:0] a;
    a = $urandom;
    e = model(4'd7, 1'b1, a, 32'h40, 64'h41);
    run_txn(4'd7, 1'b1, a, 32'h40, 64'h41, 1, 1'b1, o);
    checks++; if (o.lat !== e.lat) begin errors++; $display("FAIL pcinc latency: got %0d expected %0d", o.lat, e.lat); end
    checks++; if (o.lo !== e.lo || o.hi !== e.hi) begin errors++; $display("FAIL pcinc result: got %h_%h expected %h_%h", o.hi, o.lo, e.hi, e.lo); end
    checks++; if (o.err !== e.err) begin errors++; $display("FAIL pcinc err: got %b expected %b", o.err, e.err); end
    checks++; if (o.alu_bad !== 0) begin errors++; $display("FAIL pcinc alu_busy_ignored: got %0d bad cycles expected 0", o.alu_bad); end
    checks++; if (o.post_bad + o.busy_bad + o.unstable !== 0) begin errors++; $display("FAIL pcinc handshake: got %0d bad cycles expected 0", o.post_bad + o.busy_bad + o.unstable); end
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2;
    time gap;
    run_txn(4'd3, 1'b0, $urandom, $urandom, {$urandom, $urandom}, 0, 1'b0, o1);
    run_txn(4'd10, 1'b0, $urandom, $urandom, {$urandom, $urandom}, 0, 1'b0, o2);
    gap = (o2.acc_t - o1.acc_t) / 10;
    checks++; if (gap !== time'(S + 2)) begin errors++; $display("FAIL b2b spacing: got %0d cycles expected %0d", gap, S + 2); end
  endtask

  task automatic test_random();
    obs_t o; exp_t e;
    logic [3:0] op; logic pc; logic [DW-1:0] a, b; logic [2*DW-1:0] z;
    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(4) == 0) ? 4'd0 : 4'($urandom_range(15));
      pc = ($urandom_range(3) == 0);
      a  = $urandom;
      b  = ($urandom_range(3) == 0) ? '0 : $urandom;
      z  = {$urandom, $urandom};
      e  = model(op, pc, a, b, z);
      run_txn(op, pc, a, b, z, $urandom_range(3), 1'($urandom_range(1)), o);
      checks++; if (o.lat !== e.lat) begin errors++; $display("FAIL rand[%0d] latency: got %0d expected %0d", i, o.lat, e.lat); end
      checks++; if (o.lo !== e.lo || o.hi !== e.hi) begin errors++; $display("FAIL rand[%0d] result: op=%0d pc=%b got %h_%h expected %h_%h", i, op, pc, o.hi, o.lo, e.hi, e.lo); end
      checks++; if (o.err !== e.err) begin errors++; $display("FAIL rand[%0d] err: got %b expected %b", i, o.err, e.err); end
      checks++; if (o.alu_bad + o.unstable + o.post_bad + o.busy_bad !== 0) begin
        errors++; $display("FAIL rand[%0d] protocol: got alu=%0d stable=%0d post=%0d busy=%0d expected all 0", i, o.alu_bad, o.unstable, o.post_bad, o.busy_bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul_hold();
    test_illegal_op();
    test_div_zero();
    test_reset_mid_wait();
    test_pc_inc_busy();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
